// File: rtl/byte_store_arbiter.sv
// Two-requester round-robin arbiter in front of a single-byte store.
// Define BYTE_STORE_ARB_TIMEOUT_EN to give up on reads after TIMEOUT_CYC cycles (err pulse).
module byte_store_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       st_read_enable,
  output logic       st_write_enable,
  output logic [7:0] st_data_in,
  input  logic [7:0] st_data_out,
  input  logic       st_output_enable
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       lastServed_q, lastServed_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;

`ifdef BYTE_STORE_ARB_TIMEOUT_EN
  localparam int CntW = ($clog2(TIMEOUT_CYC) < 3) ? 3 : $clog2(TIMEOUT_CYC);
  logic [CntW-1:0] waitCnt_q, waitCnt_d;
  logic            timedOut_q, timedOut_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      lastServed_q <= 1'b1;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
`ifdef BYTE_STORE_ARB_TIMEOUT_EN
      waitCnt_q    <= '0;
      timedOut_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lastServed_q <= lastServed_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
`ifdef BYTE_STORE_ARB_TIMEOUT_EN
      waitCnt_q    <= waitCnt_d;
      timedOut_q   <= timedOut_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    lastServed_d    = lastServed_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    st_read_enable  = 1'b0;
    st_write_enable = 1'b0;
    st_data_in      = 8'h00;
`ifdef BYTE_STORE_ARB_TIMEOUT_EN
    waitCnt_d       = waitCnt_q;
    timedOut_d      = timedOut_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not served last wins.
          owner_d = (req0 && req1) ? ~lastServed_q : req1;
          wdata_d = owner_d ? wdata1 : wdata0;
          state_d = (owner_d ? wr1 : wr0) ? WRITE : READ;
`ifdef BYTE_STORE_ARB_TIMEOUT_EN
          waitCnt_d  = '0;
          timedOut_d = 1'b0;
`endif
        end
      end
      WRITE: begin
        st_write_enable = 1'b1;
        st_data_in      = wdata_q;
        state_d         = DONE;
      end
      READ: begin
        st_read_enable = 1'b1;
        if (st_output_enable) begin
          rdata_d = st_data_out;
          state_d = DONE;
        end
`ifdef BYTE_STORE_ARB_TIMEOUT_EN
        else if (waitCnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          timedOut_d = 1'b1;
          state_d    = DONE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        lastServed_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant and done decode straight from state so reset clears them immediately.
  assign gnt0  = (state_q != IDLE) && !owner_q;
  assign gnt1  = (state_q != IDLE) &&  owner_q;
  assign done0 = (state_q == DONE) && !owner_q;
  assign done1 = (state_q == DONE) &&  owner_q;
  assign rdata = rdata_q;

`ifdef BYTE_STORE_ARB_TIMEOUT_EN
  assign err = (state_q == DONE) && timedOut_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_store_arbiter.sv
// Directed self-checking bench for byte_store_arbiter; follows BYTE_STORE_ARB_TIMEOUT_EN if defined.
module tb_byte_store_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, done0, done1, err;
  logic [7:0] rdata;
  logic       st_read_enable, st_write_enable;
  logic [7:0] st_data_in;
  logic [7:0] st_data_out = 8'h00;
  logic       st_output_enable = 1'b0;

  int testsRun = 0;
  int failCount = 0;

  byte_store_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err),
    .st_read_enable(st_read_enable), .st_write_enable(st_write_enable),
    .st_data_in(st_data_in), .st_data_out(st_data_out),
    .st_output_enable(st_output_enable)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] d0,
                               input logic r1, input logic w1, input logic [7:0] d1);
    req0 = r0; wr0 = w0; wdata0 = d0;
    req1 = r1; wr1 = w1; wdata1 = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #12;
    checkOutput("rst_gnt", {gnt1, gnt0}, 8'h0);
    checkOutput("rst_done", {done1, done0}, 8'h0);
    checkOutput("rst_en", {st_read_enable, st_write_enable}, 8'h0);
    checkOutput("rst_din", st_data_in, 8'h00);
    checkOutput("rst_rdata", rdata, 8'h00);
    checkOutput("rst_err", err, 8'h0);
    rst = 1'b0;
    tick();

    // Write of 0xAA by requester 0.
    applyStimulus(1, 1, 8'hAA, 0, 0, 8'h00);
    tick();
    checkOutput("wr_gnt", {gnt1, gnt0}, 8'h1);
    checkOutput("wr_we", {st_read_enable, st_write_enable}, 8'h1);
    checkOutput("wr_din", st_data_in, 8'hAA);
    checkOutput("wr_nodone", done0, 8'h0);
    tick();
    checkOutput("wr_done", {done1, done0}, 8'h1);
    checkOutput("wr_gnt_hold", gnt0, 8'h1);
    checkOutput("wr_we_off", st_write_enable, 8'h0);
    checkOutput("wr_din_zero", st_data_in, 8'h00);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    tick();
    checkOutput("wr_idle_gnt", {gnt1, gnt0}, 8'h0);
    checkOutput("wr_idle_done", {done1, done0}, 8'h0);

    // Read by requester 1, store answers one cycle late with 0x55.
    applyStimulus(0, 0, 8'h00, 1, 0, 8'h00);
    tick();
    checkOutput("rd_gnt", {gnt1, gnt0}, 8'h2);
    checkOutput("rd_re1", {st_read_enable, st_write_enable}, 8'h2);
    checkOutput("rd_nodone", done1, 8'h0);
    st_output_enable = 1'b1;
    st_data_out      = 8'h55;
    tick();
    checkOutput("rd_done", {done1, done0}, 8'h2);
    checkOutput("rd_rdata", rdata, 8'h55);
    checkOutput("rd_re_off", st_read_enable, 8'h0);
    checkOutput("rd_err", err, 8'h0);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    st_output_enable = 1'b0;
    st_data_out      = 8'h99;
    tick();
    checkOutput("rd_idle_done", {done1, done0}, 8'h0);
    checkOutput("rd_hold", rdata, 8'h55);

    // Read with no store response: four READ cycles, then timeout or keep waiting.
    applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
    tick();
    checkOutput("to_re1", st_read_enable, 8'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("to_re_wait", {st_read_enable, done0}, 8'h2);
    end
    tick();
`ifdef BYTE_STORE_ARB_TIMEOUT_EN
    checkOutput("to_done", {err, done0}, 8'h3);
    checkOutput("to_rdata", rdata, 8'h55);
    checkOutput("to_re_off", st_read_enable, 8'h0);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    tick();
    checkOutput("to_idle", {err, done0, gnt0}, 8'h0);
`else
    checkOutput("nto_stuck", {st_read_enable, gnt0, done0, err}, 8'hC);
    st_output_enable = 1'b1;
    st_data_out      = 8'h66;
    tick();
    checkOutput("nto_done", {err, done0}, 8'h1);
    checkOutput("nto_rdata", rdata, 8'h66);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    st_output_enable = 1'b0;
    tick();
    checkOutput("nto_idle", {done0, gnt0}, 8'h0);
`endif

    // Reset in the middle of a read aborts it without a done pulse.
    applyStimulus(1, 0, 8'h00, 0, 0, 8'h00);
    tick();
    checkOutput("ab_re", st_read_enable, 8'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ab_re_off", st_read_enable, 8'h0);
    checkOutput("ab_gnt", {gnt1, gnt0}, 8'h0);
    checkOutput("ab_rdata", rdata, 8'h00);
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    tick();
    checkOutput("ab_nodone", {done1, done0}, 8'h0);
    rst = 1'b0;
    tick();
    checkOutput("ab_after", {gnt1, gnt0, done1, done0}, 8'h0);

    // Persistent tie after reset: grants alternate starting with requester 0.
    applyStimulus(1, 1, 8'h11, 1, 1, 8'h22);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rr_gnt", {gnt1, gnt0}, (i % 2 == 0) ? 8'h1 : 8'h2);
      checkOutput("rr_din", st_data_in, (i % 2 == 0) ? 8'h11 : 8'h22);
      tick();
      checkOutput("rr_done", {done1, done0}, (i % 2 == 0) ? 8'h1 : 8'h2);
      tick();
      checkOutput("rr_idle", {gnt1, gnt0}, 8'h0);
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
